// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// The FIFO entry record carries the destination, data and trace PC of one MDU result.
package rf_wb_arbiter_pkg;

  localparam int NUM_REGS = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Widest trace PC an entry can hold; the top narrows or widens to its PW.
  localparam int PC_W = 32;

  typedef struct packed {
    logic [4:0]      rd;
    logic [31:0]     wd;
    logic [PC_W-1:0] pc;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// Parametric synchronous FIFO with a combinational head; DEPTH must be a power of two.
// Push while full is accepted only when a pop happens on the same edge.
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between the W stage (fixed priority) and
// queued MDU results, and tracks outstanding MDU destinations in a busy scoreboard.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_we,
  input  logic [4:0]    wb_a3,
  input  logic [31:0]   wb_wd,
  input  logic [PW-1:0] wb_pc,
  input  logic          iss_valid,
  input  logic [4:0]    iss_rd,
  output logic          iss_ready,
  input  logic          mdu_valid,
  input  logic [4:0]    mdu_rd,
  input  logic [31:0]   mdu_wd,
  input  logic [PW-1:0] mdu_pc,
  output logic          mdu_ready,
  input  logic [4:0]    d_rs,
  input  logic [4:0]    d_rt,
  output logic          d_stall,
  output logic          pipe_hold,
  output logic          rf_we,
  output logic [4:0]    rf_a3,
  output logic [31:0]   rf_wd,
  output logic [PW-1:0] rf_pc
);

  // Handshake: a transfer happens on an edge where valid && ready; mdu_ready and
  // iss_ready depend only on registered state plus the offered destination.

  logic               wb_active;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  wb_entry_t          fifo_din;
  logic [ENTRY_W-1:0] head_raw;
  wb_entry_t          head;
  logic               iss_fire;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  assign wb_active = wb_we && (wb_a3 != REG_ZERO);
  assign mdu_ready = !fifo_full;
  assign fifo_push = mdu_valid && mdu_ready;
  // Queued results never reach the port while reset is asserted, so a reset
  // mid-transfer discards them.
  assign fifo_pop  = !reset && !wb_active && !fifo_empty;

  assign fifo_din.rd = mdu_rd;
  assign fifo_din.wd = mdu_wd;
  assign fifo_din.pc = PC_W'(mdu_pc);
  assign head        = wb_entry_t'(head_raw);

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head_raw)
  );

  always_comb begin
    rf_we = 1'b0;
    rf_a3 = '0;
    rf_wd = '0;
    rf_pc = '0;
    if (wb_active) begin
      rf_we = 1'b1;
      rf_a3 = wb_a3;
      rf_wd = wb_wd;
      rf_pc = wb_pc;
    end else if (fifo_pop && (head.rd != REG_ZERO)) begin
      // A $0 head still pops, but its slot leaves the port idle.
      rf_we = 1'b1;
      rf_a3 = head.rd;
      rf_wd = head.wd;
      rf_pc = PW'(head.pc);
    end
  end

  assign iss_ready = (iss_rd == REG_ZERO) || !busy_q[iss_rd];
  assign iss_fire  = iss_valid && iss_ready && (iss_rd != REG_ZERO);
  assign d_stall   = ((d_rs != REG_ZERO) && busy_q[d_rs]) ||
                     ((d_rt != REG_ZERO) && busy_q[d_rt]);

  // Clear on retirement first so a same-register issue in that cycle wins.
  always_comb begin
    busy_d = busy_q;
    if (fifo_pop && (head.rd != REG_ZERO)) busy_d[head.rd] = 1'b0;
    if (iss_fire) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= '0;
      pipe_hold <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      pipe_hold <= fifo_full && wb_active;
    end
  end

endmodule
